// File: rtl/axis_rr_arbiter.sv
// AXI4-Stream N:1 packet arbiter: round-robin grant held for a whole packet,
// registered output stage, grant index exported alongside the stream.
module axis_rr_arbiter #(
  parameter int  NUM_SRC    = 4,
  parameter int  DWIDTH     = 32,
  parameter int  ID_WIDTH   = 4,
  parameter int  DEST_WIDTH = 1,
  parameter int  USER_WIDTH = 4,
  localparam int SEL_W      = $clog2(NUM_SRC),
  localparam int KWIDTH     = DWIDTH / 8
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [NUM_SRC-1:0]               s_tvalid,
  output logic [NUM_SRC-1:0]               s_tready,
  input  logic [NUM_SRC*DWIDTH-1:0]        s_tdata,
  input  logic [NUM_SRC*KWIDTH-1:0]        s_tkeep,
  input  logic [NUM_SRC*KWIDTH-1:0]        s_tstrb,
  input  logic [NUM_SRC-1:0]               s_tlast,
  input  logic [NUM_SRC*ID_WIDTH-1:0]      s_tid,
  input  logic [NUM_SRC*DEST_WIDTH-1:0]    s_tdest,
  input  logic [NUM_SRC*USER_WIDTH-1:0]    s_tuser,
  output logic                             m_tvalid,
  input  logic                             m_tready,
  output logic [DWIDTH-1:0]                m_tdata,
  output logic [KWIDTH-1:0]                m_tkeep,
  output logic [KWIDTH-1:0]                m_tstrb,
  output logic                             m_tlast,
  output logic [ID_WIDTH-1:0]              m_tid,
  output logic [DEST_WIDTH-1:0]            m_tdest,
  output logic [USER_WIDTH-1:0]            m_tuser,
  output logic [SEL_W-1:0]                 grant_idx,
  output logic                             busy
);

  typedef enum logic {ST_IDLE, ST_LOCK} state_e;

  state_e                  state_q;
  logic [SEL_W-1:0]        grant_q, grant_d, last_q;
  logic                    busy_q;
  logic                    mvalid_q, mlast_q;
  logic [DWIDTH-1:0]       mdata_q;
  logic [KWIDTH-1:0]       mkeep_q, mstrb_q;
  logic [ID_WIDTH-1:0]     mid_q;
  logic [DEST_WIDTH-1:0]   mdest_q;
  logic [USER_WIDTH-1:0]   muser_q;

  logic                    out_ok, accept, accept_last;
  int                      idx;

  // Round-robin search from last+1 upward; iterating downward lets the
  // nearest requester overwrite farther ones.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_d = '0;
    idx     = 0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = (int'(last_q) + k) % NUM_SRC;
      if (|(s_tvalid & (NUM_SRC'(1) << idx))) grant_d = SEL_W'(idx);
    end
  end

  assign out_ok      = !mvalid_q || m_tready;
  assign s_tready    = (state_q == ST_LOCK) ? (NUM_SRC'(out_ok) << grant_q) : '0;
  assign accept      = |(s_tvalid & s_tready);
  assign accept_last = |(s_tvalid & s_tready & s_tlast);

  // NOTE: all state below is updated with non-blocking assignments only.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      last_q   <= SEL_W'(NUM_SRC - 1);
      busy_q   <= 1'b0;
      mvalid_q <= 1'b0;
      mdata_q  <= '0;
      mkeep_q  <= '0;
      mstrb_q  <= '0;
      mlast_q  <= 1'b0;
      mid_q    <= '0;
      mdest_q  <= '0;
      muser_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|s_tvalid) begin
            grant_q <= grant_d;
            busy_q  <= 1'b1;
            state_q <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (accept_last) begin
            last_q  <= grant_q;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Payload only moves on an accepted beat, so it is frozen while stalled.
      if (accept) begin
        mvalid_q <= 1'b1;
        mdata_q  <= DWIDTH'(s_tdata >> (int'(grant_q) * DWIDTH));
        mkeep_q  <= KWIDTH'(s_tkeep >> (int'(grant_q) * KWIDTH));
        mstrb_q  <= KWIDTH'(s_tstrb >> (int'(grant_q) * KWIDTH));
        mlast_q  <= accept_last;
        mid_q    <= ID_WIDTH'(s_tid >> (int'(grant_q) * ID_WIDTH));
        mdest_q  <= DEST_WIDTH'(s_tdest >> (int'(grant_q) * DEST_WIDTH));
        muser_q  <= USER_WIDTH'(s_tuser >> (int'(grant_q) * USER_WIDTH));
      end else if (m_tready) begin
        mvalid_q <= 1'b0;
      end
    end
  end

  assign m_tvalid  = mvalid_q;
  assign m_tdata   = mdata_q;
  assign m_tkeep   = mkeep_q;
  assign m_tstrb   = mstrb_q;
  assign m_tlast   = mlast_q;
  assign m_tid     = mid_q;
  assign m_tdest   = mdest_q;
  assign m_tuser   = muser_q;
  assign grant_idx = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: per-source packet queues drive the DUT,
// a packet-level round-robin model predicts the output beat stream.
module tb_axis_rr_arbiter;
  localparam int N = 4, DW = 32, KW = 4, IW = 4, DSW = 1, UW = 4, SW = 2;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [KW-1:0]  keep;
    logic [KW-1:0]  strb;
    logic           last;
    logic [IW-1:0]  id;
    logic [DSW-1:0] dest;
    logic [UW-1:0]  user;
  } beat_t;
  typedef struct { beat_t b; int gap; } sbeat_t;
  typedef struct { beat_t b; int src; } ebeat_t;
  typedef struct {
    logic mvalid; beat_t b; logic [N-1:0] sready; logic busy; logic [SW-1:0] grant;
  } snap_t;

  logic              aclk = 1'b0;
  logic              areset;
  logic [N-1:0]      s_tvalid, s_tready, s_tlast;
  logic [N*DW-1:0]   s_tdata;
  logic [N*KW-1:0]   s_tkeep, s_tstrb;
  logic [N*IW-1:0]   s_tid;
  logic [N*DSW-1:0]  s_tdest;
  logic [N*UW-1:0]   s_tuser;
  logic              m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep, m_tstrb;
  logic [IW-1:0]     m_tid;
  logic [DSW-1:0]    m_tdest;
  logic [UW-1:0]     m_tuser;
  logic [SW-1:0]     grant_idx;
  logic              busy;

  axis_rr_arbiter #(.NUM_SRC(N), .DWIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) dut (
    .aclk(aclk), .areset(areset),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tstrb(s_tstrb), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tstrb(m_tstrb), .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
    .grant_idx(grant_idx), .busy(busy)
  );

  always #5 aclk = ~aclk;

  beat_t  out_b;
  assign out_b = {m_tdata, m_tkeep, m_tstrb, m_tlast, m_tid, m_tdest, m_tuser};

  sbeat_t src_q[N][$];
  ebeat_t exp_q[$];
  int     wait_cnt[N];
  int     model_last;
  logic   rdy_pat[$];
  logic   rdy_random;
  snap_t  hist[256];
  int     pc;
  int     n_checks = 0, n_fail = 0;
  int     seq = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake, checks AXI stall rules.
  initial begin
    ebeat_t e;
    beat_t  held_b;
    logic   prev_stall;
    prev_stall = 1'b0;
    held_b     = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        prev_stall = 1'b0;
      end else begin
        check("sready_only_grant", 64'(s_tready & ~(N'(1) << grant_idx)), 64'(0));
        if (prev_stall) check("stall_payload_hold", 64'(out_b), 64'(held_b));
        if (m_tvalid && !m_tready) check("sready_while_stalled", 64'(s_tready), 64'(0));
        if (m_tvalid && m_tready) begin
          check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat_payload", 64'(out_b), 64'(e.b));
            if (!m_tlast) check("beat_grant", 64'(grant_idx), 64'(e.src));
          end
        end
        prev_stall = m_tvalid && !m_tready;
        held_b     = out_b;
      end
    end
  end

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += src_q[i].size();
    return s;
  endfunction

  function automatic int first_valid();
    for (int i = 0; i < pc && i < 256; i++) if (hist[i].mvalid) return i;
    return -1;
  endfunction

  task automatic load_pkt(input int src, input int nbeats, input logic [31:0] base,
                          input logic [31:0] step, input int gap_at, input int gap_len);
    sbeat_t sb;
    for (int j = 0; j < nbeats; j++) begin
      sb.b.data = base + step * j;
      sb.b.keep = KW'($urandom);
      sb.b.strb = KW'($urandom);
      sb.b.last = (j == nbeats - 1);
      sb.b.id   = IW'(src);
      sb.b.dest = DSW'($urandom);
      sb.b.user = UW'($urandom);
      sb.gap    = (j > 0 && j == gap_at) ? gap_len : 0;
      src_q[src].push_back(sb);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      beat_t b;
      logic  v;
      b = '0;
      v = 1'b0;
      if (src_q[i].size() > 0) begin
        b = src_q[i][0].b;
        v = (wait_cnt[i] == 0);
      end
      s_tvalid[i]          = v;
      s_tdata[i*DW +: DW]  = b.data;
      s_tkeep[i*KW +: KW]  = b.keep;
      s_tstrb[i*KW +: KW]  = b.strb;
      s_tlast[i]           = b.last;
      s_tid[i*IW +: IW]    = b.id;
      s_tdest[i*DSW +: DSW] = b.dest;
      s_tuser[i*UW +: UW]  = b.user;
    end
  endtask

  task automatic run_cycle();
    logic [N-1:0] hs;
    drive();
    if (rdy_pat.size() > 0) m_tready = rdy_pat.pop_front();
    else if (rdy_random)    m_tready = ($urandom_range(0, 9) < 7);
    else                    m_tready = 1'b1;
    @(negedge aclk);
    hs = s_tvalid & s_tready;
    if (pc < 256) hist[pc] = '{mvalid: m_tvalid, b: out_b, sready: s_tready, busy: busy, grant: grant_idx};
    pc++;
    @(posedge aclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        void'(src_q[i].pop_front());
        wait_cnt[i] = (src_q[i].size() > 0) ? src_q[i][0].gap : 0;
      end else if (wait_cnt[i] > 0) begin
        wait_cnt[i]--;
      end
    end
  endtask

  // Reference: whole packets granted round-robin over sources with packets pending.
  task automatic start_phase();
    sbeat_t mq[N][$];
    sbeat_t sb;
    int     idx;
    logic   found;
    for (int i = 0; i < N; i++) mq[i] = src_q[i];
    while ((mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()) != 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        idx = (model_last + k) % N;
        if (!found && mq[idx].size() > 0) begin
          found = 1'b1;
          do begin
            sb = mq[idx].pop_front();
            exp_q.push_back('{b: sb.b, src: idx});
          end while (!sb.b.last);
          model_last = idx;
        end
      end
    end
    pc = 0;
  endtask

  task automatic run_phase(input int min_cyc, input int max_cyc);
    int n = 0;
    start_phase();
    while (n < max_cyc && (n < min_cyc || exp_q.size() != 0 || pending() != 0)) begin
      run_cycle();
      n++;
    end
    check("phase_drained", 64'(exp_q.size() + pending()), 64'(0));
  endtask

  task automatic do_reset();
    areset   = 1'b1;
    s_tvalid = '1;
    s_tdata  = {$urandom, $urandom, $urandom, $urandom};
    s_tlast  = '1;
    m_tready = 1'b1;
    #1;
    check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_s_tready", 64'(s_tready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_grant_idx", 64'(grant_idx), 64'(0));
    check("rst_payload", 64'(out_b), 64'(0));
    repeat (2) @(posedge aclk);
    #1;
    check("rst_hold_s_tready", 64'(s_tready), 64'(0));
    check("rst_hold_busy", 64'(busy), 64'(0));
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      wait_cnt[i] = 0;
    end
    exp_q.delete();
    model_last = N - 1;
    s_tvalid   = '0;
    areset     = 1'b0;
  endtask

  initial begin
    int fi, lv, cnt, k;
    areset = 1'b1; s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tstrb = '0; s_tlast = '0;
    s_tid = '0; s_tdest = '0; s_tuser = '0; m_tready = 1'b1; rdy_random = 1'b0;
    model_last = N - 1;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    do_reset();

    // Single 3-beat packet from source 0: latency and busy timing.
    load_pkt(0, 3, 32'h11, 32'h11, 0, 0);
    run_phase(8, 50);
    check("t1_c0_sready", 64'(hist[0].sready), 64'(0));
    check("t1_c0_busy", 64'(hist[0].busy), 64'(0));
    check("t1_c1_sready", 64'(hist[1].sready), 64'(4'b0001));
    check("t1_c1_busy", 64'(hist[1].busy), 64'(1));
    check("t1_c1_grant", 64'(hist[1].grant), 64'(0));
    check("t1_c1_mvalid", 64'(hist[1].mvalid), 64'(0));
    for (int j = 0; j < 3; j++) begin
      check("t1_out_valid", 64'(hist[2+j].mvalid), 64'(1));
      check("t1_out_data", 64'(hist[2+j].b.data), 64'(32'h11 * (j + 1)));
      check("t1_out_last", 64'(hist[2+j].b.last), 64'(j == 2));
    end
    check("t1_busy_before_last", 64'(hist[3].busy), 64'(1));
    check("t1_busy_after_last", 64'(hist[4].busy), 64'(0));
    check("t1_c5_mvalid", 64'(hist[5].mvalid), 64'(0));

    // last=0 now: simultaneous single beats from 0 and 3 -> 3 first.
    load_pkt(0, 1, 32'h500, 0, 0, 0);
    load_pkt(3, 1, 32'h503, 0, 0, 0);
    run_phase(4, 50);
    fi = first_valid();
    check("t5_first_src", 64'((fi >= 0) ? hist[fi].b.id : 4'hF), 64'(3));

    // Source 2 stalled by m_tready pattern 1,0,0,1 on its second output beat.
    rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    load_pkt(2, 3, 32'hA0, 32'h1, 0, 0);
    run_phase(8, 50);
    check("t3_stall1_sready", 64'(hist[3].sready), 64'(0));
    check("t3_stall2_sready", 64'(hist[4].sready), 64'(0));
    for (int j = 3; j <= 5; j++) check("t3_stall_data", 64'(hist[j].b.data), 64'(32'hA1));
    check("t3_after_data", 64'(hist[6].b.data), 64'(32'hA2));
    check("t3_after_last", 64'(hist[6].b.last), 64'(1));

    // All sources busy with 2-beat packets: order 0,1,2,3,... and one bubble each.
    @(posedge aclk); #1;
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) load_pkt(i, 2, 32'h1000 * (i + 1) + 32'h10 * r, 1, 0, 0);
    run_phase(4, 100);
    fi = first_valid(); lv = -1; cnt = 0; k = 0;
    for (int i = 0; i < pc && i < 256; i++) begin
      if (hist[i].mvalid) begin
        cnt++; lv = i;
        if (hist[i].b.last) begin
          check("t2_order", 64'(hist[i].b.id), 64'(k % N));
          k++;
        end
      end
    end
    check("t2_beats", 64'(cnt), 64'(16));
    check("t2_span", 64'(lv - fi + 1), 64'(23));

    // Source 1 pauses 5 cycles mid-packet while source 3 waits.
    @(posedge aclk); #1;
    do_reset();
    load_pkt(1, 3, 32'h2100, 1, 1, 5);
    load_pkt(3, 2, 32'h2300, 1, 0, 0);
    run_phase(4, 100);
    fi = first_valid();
    check("t4_first_src", 64'((fi >= 0) ? hist[fi].b.id : 4'hF), 64'(1));

    // Reset in the middle of a 4-beat packet from source 2.
    @(posedge aclk); #1;
    do_reset();
    load_pkt(2, 4, 32'h3000, 1, 0, 0);
    start_phase();
    repeat (3) run_cycle();
    check("t6_pre_grant", 64'(grant_idx), 64'(2));
    check("t6_pre_mvalid", 64'(hist[2].mvalid), 64'(1));
    do_reset();
    load_pkt(0, 2, 32'h3100, 1, 0, 0);
    load_pkt(2, 2, 32'h3200, 1, 0, 0);
    run_phase(4, 100);
    fi = first_valid();
    check("t6_post_first_src", 64'((fi >= 0) ? hist[fi].b.id : 4'hF), 64'(0));

    // Randomised traffic with random back-pressure and mid-packet gaps.
    rdy_random = 1'b1;
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin
        int npk;
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) begin
          load_pkt(i, $urandom_range(1, 4), {8'(i), 24'(seq)}, 1, $urandom_range(1, 3), $urandom_range(0, 3));
          seq += 16;
        end
      end
      run_phase(0, 400);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish, got t=%0t", $time);
    $fatal(1);
  end

endmodule
